// File: rtl/rand_inst_sched.sv
// Sequencer for the instruction randomizer: LFSR-driven opcode templates in,
// randomized instructions out to the instruction-memory writer over valid/ready.
`timescale 1ns/1ps

module rand_inst_sched #(
  parameter int          CNT_W    = 8,
  parameter logic [15:0] DEF_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [15:0]      seed,
  input  logic [CNT_W-1:0] num_inst,
  input  logic [15:0]      rand_inst,
  output logic [15:0]      rand_data,
  output logic [15:0]      inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_inst,
  output logic [CNT_W-1:0] out_addr,
  output logic             busy,
  output logic             done
);

  // state  | meaning
  // IDLE   | waiting for start
  // GEN    | capture randomizer result for index cnt
  // HOLD   | out_valid high, waiting for out_ready
  // DONE   | one-cycle completion pulse
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GEN  = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  state_t           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic             out_valid_q, out_valid_d;
  logic [15:0]      out_inst_q, out_inst_d;
  logic [CNT_W-1:0] out_addr_q, out_addr_d;

  logic [15:0]      lfsr_next;
  logic [3:0]       opcode;
  logic             handshake;
  logic             last_inst;

  assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

  // Only opcodes 0..12 exist; fold the three spare LFSR codes back onto 0..2.
  always_comb begin
    opcode = lfsr_q[15:12];
    case (lfsr_q[15:12])
      4'd13:   opcode = 4'd0;
      4'd14:   opcode = 4'd1;
      4'd15:   opcode = 4'd2;
      default: opcode = lfsr_q[15:12];
    endcase
  end

  assign inst      = {opcode, 12'h000};
  assign rand_data = {lfsr_q[7:0], lfsr_q[15:8]};

  assign handshake = out_valid_q & out_ready;
  assign last_inst = (cnt_q == num_q - 1'b1);

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    cnt_d       = cnt_q;
    num_d       = num_q;
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_addr_d  = out_addr_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          lfsr_d  = (seed == 16'h0000) ? DEF_SEED : seed;
          cnt_d   = '0;
          num_d   = num_inst;
          state_d = (num_inst == '0) ? S_DONE : S_GEN;
        end
      end
      S_GEN: begin
        if (abort) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          out_inst_d  = rand_inst;
          out_addr_d  = cnt_q;
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        // Abort wins over a handshake in the same cycle: nothing is consumed.
        if (abort) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else if (handshake) begin
          out_valid_d = 1'b0;
          lfsr_d      = lfsr_next;
          cnt_d       = cnt_q + 1'b1;
          state_d     = last_inst ? S_DONE : S_GEN;
        end
      end
      S_DONE: begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lfsr_q      <= DEF_SEED;
      cnt_q       <= '0;
      num_q       <= '0;
      out_valid_q <= 1'b0;
      out_inst_q  <= 16'h0000;
      out_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      cnt_q       <= cnt_d;
      num_q       <= num_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_addr_q  <= out_addr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_addr  = out_addr_q;
  assign busy      = (state_q != S_IDLE);
  // An abort arriving in DONE also suppresses the completion pulse.
  assign done      = (state_q == S_DONE) && !abort;

endmodule

// File: tb/tb_rand_inst_sched.sv
// Self-checking bench for rand_inst_sched: directed scenarios plus randomized
// runs compared against an arithmetic model of the LFSR/opcode rules.
`timescale 1ns/1ps

module tb_rand_inst_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] seed;
  logic [7:0]  num_inst;
  logic [15:0] rand_inst;
  logic [15:0] rand_data;
  logic [15:0] inst;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_inst;
  logic [7:0]  out_addr;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rand_inst_sched #(.CNT_W(8), .DEF_SEED(16'hACE1)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .seed      (seed),
    .num_inst  (num_inst),
    .rand_inst (rand_inst),
    .rand_data (rand_data),
    .inst      (inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_addr  (out_addr),
    .busy      (busy),
    .done      (done)
  );

  // Stand-in for the combinational randomizer: opcode kept, fields scrambled by the data.
  function automatic logic [15:0] randomizer(input logic [15:0] t, input logic [15:0] d);
    return {t[15:12], d[11:0] ^ {8'h00, d[15:12]}};
  endfunction

  assign rand_inst = randomizer(inst, rand_data);

  // Reference model, plain integer arithmetic.
  function automatic int m_next(input int l);
    return (l >> 1) ^ (((l % 2) == 1) ? 'hB400 : 0);
  endfunction

  function automatic int m_opc(input int l);
    int o;
    o = (l >> 12) & 15;
    return (o > 12) ? o - 13 : o;
  endfunction

  function automatic int m_rdata(input int l);
    return ((l & 'hFF) << 8) | ((l >> 8) & 'hFF);
  endfunction

  function automatic int m_seed(input int s);
    return (s == 0) ? 'hACE1 : s;
  endfunction

  function automatic logic [15:0] m_inst(input int l);
    logic [15:0] t, d;
    t = 16'(m_opc(l) << 12);
    d = 16'(m_rdata(l));
    return randomizer(t, d);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete run; rdy_pct=100 also checks the exact done cycle.
  // poke: pulse start with other settings mid-run and alter num_inst.
  task automatic do_run(input logic [15:0] s, input int n, input int rdy_pct, input bit poke);
    logic [15:0] exp_inst[$];
    logic [15:0] exp_rd[$];
    int l, idx, cyc, done_cyc, limit;
    bit ready;
    l = m_seed(int'(s));
    for (int i = 0; i < n; i++) begin
      exp_inst.push_back(m_inst(l));
      exp_rd.push_back(16'(m_rdata(l)));
      l = m_next(l);
    end
    seed = s;
    num_inst = 8'(n);
    start = 1'b1;
    out_ready = 1'b0;
    tick();
    start = 1'b0;
    idx = 0;
    cyc = 1;
    done_cyc = -1;
    limit = 40 * n + 20;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    while (done_cyc < 0 && cyc < limit) begin
      if (out_valid === 1'b1) begin
        chk("valid_in_range", {31'd0, idx < n}, 32'd1);
        if (idx < n) begin
          chk("out_addr", {24'd0, out_addr}, 32'(idx));
          chk("out_inst", {16'd0, out_inst}, {16'd0, exp_inst[idx]});
          chk("rand_data_hold", {16'd0, rand_data}, {16'd0, exp_rd[idx]});
        end
      end
      if (done === 1'b1) begin
        done_cyc = cyc;
        chk("done_count", 32'(idx), 32'(n));
      end else begin
        chk("busy_running", {31'd0, busy}, 32'd1);
      end
      if (poke && cyc == 3) begin
        start = 1'b1;
        seed = 16'h0F0F;
        num_inst = 8'(n + 5);
      end else begin
        start = 1'b0;
      end
      ready = ($urandom_range(99) < rdy_pct);
      out_ready = ready;
      if (out_valid === 1'b1 && ready) idx++;
      tick();
      cyc++;
    end
    start = 1'b0;
    out_ready = 1'b0;
    if (done_cyc < 0) chk("done_timeout", 32'(cyc), 32'(limit + 1));
    else if (rdy_pct >= 100) chk("done_cycle", 32'(done_cyc), 32'(2 * n + 1));
    chk("idle_after_done", {30'd0, busy, done}, 32'd0);
    chk("valid_after_done", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int l0, l1;
    logic [15:0] e0, e1;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    seed = 16'h0000;
    num_inst = 8'd0;
    out_ready = 1'b0;

    // Reset values
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rand_data", {16'd0, rand_data}, 32'h0000E1AC);
    chk("rst_inst", {16'd0, inst}, 32'h0000A000);
    chk("rst_out_inst", {16'd0, out_inst}, 32'd0);
    chk("rst_out_addr", {24'd0, out_addr}, 32'd0);
    rst = 1'b0;
    tick();

    // Seed 0 uses the default seed; two instructions, ready tied high
    do_run(16'h0000, 2, 100, 1'b0);
    chk("seed0_lfsr_adv", {16'd0, rand_data}, 32'(m_rdata(m_next(m_next('hACE1)))));

    // num_inst=0: DONE in cycle 1, no valid
    do_run(16'h1357, 0, 100, 1'b0);

    // num_inst=1
    do_run(16'h8001, 1, 100, 1'b0);

    // start while busy ignored; num_inst change mid-run has no effect
    do_run(16'h1234, 3, 100, 1'b1);
    num_inst = 8'd0;

    // Backpressure: 7 cycles of out_ready=0 in HOLD, then exactly one handshake
    l0 = 'hBEEF;
    l1 = m_next(l0);
    e0 = m_inst(l0);
    e1 = m_inst(l1);
    seed = 16'hBEEF;
    num_inst = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int k = 0; k < 7; k++) begin
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_inst", {16'd0, out_inst}, {16'd0, e0});
      chk("bp_addr", {24'd0, out_addr}, 32'd0);
      chk("bp_lfsr", {16'd0, rand_data}, 32'(m_rdata(l0)));
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_gen_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_lfsr_adv", {16'd0, rand_data}, 32'(m_rdata(l1)));
    tick();
    chk("bp_next_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_next_addr", {24'd0, out_addr}, 32'd1);
    chk("bp_next_inst", {16'd0, out_inst}, {16'd0, e1});
    tick();
    tick();
    chk("bp_one_hs_addr", {24'd0, out_addr}, 32'd1);
    chk("bp_one_hs_lfsr", {16'd0, rand_data}, 32'(m_rdata(l1)));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("bp_abort_idle", {31'd0, busy}, 32'd0);

    // Abort in HOLD together with out_ready
    l0 = 'h5A5A;
    seed = 16'h5A5A;
    num_inst = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("ab_hold_valid", {31'd0, out_valid}, 32'd1);
    abort = 1'b1;
    out_ready = 1'b1;
    tick();
    abort = 1'b0;
    out_ready = 1'b0;
    chk("ab_busy", {31'd0, busy}, 32'd0);
    chk("ab_valid", {31'd0, out_valid}, 32'd0);
    chk("ab_done", {31'd0, done}, 32'd0);
    chk("ab_lfsr_kept", {16'd0, rand_data}, 32'(m_rdata(l0)));
    chk("ab_addr_kept", {24'd0, out_addr}, 32'd0);
    tick();
    chk("ab_no_done_later", {31'd0, done}, 32'd0);

    // Reset in HOLD
    seed = 16'h7777;
    num_inst = 8'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("mr_hold_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_valid", {31'd0, out_valid}, 32'd0);
    chk("mr_out_inst", {16'd0, out_inst}, 32'd0);
    chk("mr_out_addr", {24'd0, out_addr}, 32'd0);
    chk("mr_rand_data", {16'd0, rand_data}, 32'h0000E1AC);
    chk("mr_inst", {16'd0, inst}, 32'h0000A000);
    tick();

    // Full-length run: indices 0..254
    do_run(16'hC0DE, 255, 100, 1'b0);

    // Randomized runs with random backpressure
    for (int r = 0; r < 6; r++) begin
      do_run(16'($urandom), int'($urandom_range(1, 12)), 50, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rand_inst_sched.md
# rand_inst_sched

Sequencer for the instruction randomizer. It generates a 16-bit LFSR random stream and builds an opcode template from it. It drives `rand_data`/`inst` into the combinational randomizer and registers the returned `rand_inst`. It then issues a programmed number of randomized instructions to the instruction-memory writer over a valid/ready handshake. It sits between the test-program loader and the processor instruction memory.

## Interface
Parameters:
- `CNT_W`, 8: width of instruction count and address.
- `DEF_SEED`, 16'hACE1: LFSR value used at reset and whenever `seed` is 0.

Ports:
- `clk`  in  1  single clock, all logic rising-edge.
- `rst`  in  1  reset is synchronous and active-high.
- `start`  in  1  begin a run; sampled only in IDLE.
- `abort`  in  1  cancel a run in progress.
- `seed`  in  16  LFSR seed, sampled with `start`.
- `num_inst`  in  CNT_W  number of instructions to issue.
- `rand_inst`  in  16  randomized instruction returned from the randomizer.
- `rand_data`  out  16  random field data to the randomizer.
- `inst`  out  16  template instruction to the randomizer.
- `out_valid`  out  1  `out_inst`/`out_addr` are valid.
- `out_ready`  in  1  downstream accepts the current instruction.
- `out_inst`  out  16  registered randomized instruction.
- `out_addr`  out  CNT_W  instruction index, 0..num_inst-1.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse when a run completes.

## Operation
- LFSR is a 16-bit Galois register, right-shift, taps 16'hB400.
  - Next value = `{1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 0)`.
  - It advances only on a handshake (`out_valid & out_ready`).
- The template opcode comes from `lfsr[15:12]`.
  - Values 0..12 are used as-is.
  - Values 13, 14 and 15 map to 0, 1 and 2.
- `inst = {opcode, 12'h000}` and `rand_data = {lfsr[7:0], lfsr[15:8]}`. Both are combinational from the LFSR.
- States are IDLE, GEN, HOLD, DONE. Reset enters IDLE.
- IDLE:
  - `start=1` loads the LFSR with `seed` (or `DEF_SEED` if `seed==0`) and clears `cnt`.
  - If `num_inst==0` the next state is DONE; otherwise GEN.
- GEN:
  - Captures `out_inst <= rand_inst`, `out_addr <= cnt`, `out_valid <= 1`.
  - Next state is HOLD.
- HOLD:
  - `out_valid`, `out_inst` and `out_addr` are held stable until `out_ready=1`.
  - On handshake: clear `out_valid`, advance the LFSR and increment `cnt`.
  - If `cnt == num_inst-1`, go to DONE; otherwise go to GEN.
- DONE: `done=1` for exactly one cycle, then IDLE.
- `num_inst` is sampled into an internal register at `start`. Later changes to the `num_inst` input have no effect on a run in progress.
- `start` outside IDLE is ignored.
- `abort=1` in GEN, HOLD or DONE forces IDLE on the next edge.
  - `out_valid` goes to 0 and no `done` pulse is produced.
  - The LFSR and `cnt` keep their values.
  - `abort` has priority over a simultaneous handshake.
- `busy` is 1 whenever the state is not IDLE.

## Timing
- Reset values:
  - `out_valid=0`, `out_inst=0`, `out_addr=0`, `done=0`, `busy=0`.
  - LFSR = `DEF_SEED`, so `rand_data=16'hE1AC` and `inst=16'hA000`.
- Start latency:
  - `start` is sampled at edge 0.
  - GEN is active in cycle 1.
  - `out_valid=1` from cycle 2.
- With `out_ready` tied high, throughput is one instruction per 2 cycles.
- A run of N instructions with `out_ready` tied high has its `done` pulse in cycle 2N+1 after the start edge.
- Boundary cases:
  - `num_inst=1`: one instruction, then DONE.
  - `num_inst=255`: indices 0..254 are issued.
  - `cnt` never wraps.
- Reset mid-run returns to IDLE with all reset values on the next edge.

## Test plan
- **Reset:** hold `rst` for 2 cycles -> `busy=0`, `out_valid=0`, `rand_data=16'hE1AC`, `inst=16'hA000`.
- **Seed 0, num_inst=2, out_ready=1:**
  - Instruction 0 is `out_inst=16'hA3AC` at `out_addr=0`, showing register 0 remapped to register 1.
  - Instruction 1 is `out_inst=16'h12E0` at `out_addr=1`.
  - `done` pulses in cycle 5.
- **Backpressure:** keep `out_ready=0` for 7 cycles in HOLD -> `out_valid`, `out_inst` and `out_addr` stay constant and the LFSR does not advance. Raise `out_ready` -> exactly one handshake.
- **num_inst=0 with start:** -> DONE in cycle 1, single `done` pulse, `out_valid` never asserted.
- **Abort in HOLD with out_ready=1 in the same cycle:** -> IDLE next cycle, `out_valid=0`, no `done`, `cnt` not incremented.
- **start while busy and rst mid-run:**
  - `start` while busy is ignored and the run completes normally.
  - `rst` asserted in HOLD gives reset values on the next cycle.
